// File: rtl/word_compressor_if.sv
// Stream bundle between a word source, the word compressor and the beat sink.
// The slave modport is the compressor's view; the master modport is the source/sink side.
interface word_compressor_if #(
    parameter int WIDTH   = 32,
    parameter int O_WIDTH = 128,
    parameter int FILL_W  = 8
);
    logic               i_valid;
    logic               o_ready;
    logic [WIDTH-1:0]   i_data;
    logic               i_flush;
    logic               o_flush_ack;
    logic               o_valid;
    logic               i_ready;
    logic [O_WIDTH-1:0] o_data;
    logic               o_last;
    logic [FILL_W-1:0]  o_bits;

    modport slave (
        input  i_valid, i_data, i_flush, i_ready,
        output o_ready, o_flush_ack, o_valid, o_data, o_last, o_bits
    );

    modport master (
        output i_valid, i_data, i_flush, i_ready,
        input  o_ready, o_flush_ack, o_valid, o_data, o_last, o_bits
    );
endinterface

// File: rtl/word_compressor.sv
// Dictionary-based word compressor: classifies each word against a 16-entry FIFO
// dictionary and packs variable-length codes LSB-first into 128-bit beats.
module word_compressor #(
    parameter int WIDTH       = 32,
    parameter int WORD        = 16,
    parameter int O_WIDTH     = 128,
    parameter int LENGTH_CODE = 2,
    parameter int LENGTH      = 6,
    parameter int FILL_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    word_compressor_if.slave  bus
);
    localparam int IDX_W  = $clog2(WORD);
    localparam int HALF   = WIDTH / 2;
    localparam int CODE_W = WIDTH + LENGTH_CODE;
    localparam int ACC_W  = O_WIDTH + CODE_W;
    localparam logic [FILL_W:0]   BEAT_BITS = (FILL_W+1)'(O_WIDTH);
    localparam logic [FILL_W-1:0] FULL_BITS = FILL_W'(O_WIDTH);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [O_WIDTH-1:0]   o_data_q, o_data_d;
    logic [FILL_W-1:0]    o_bits_q, o_bits_d;
    logic                 o_last_q, o_last_d;
    logic                 o_valid_q, o_valid_d;
    logic                 o_flush_ack_q, o_flush_ack_d;

    logic [WIDTH-1:0]     dict_q [WORD];
    logic [WORD-1:0]      dict_vld_q;

    logic [WORD-1:0]      full_vec_s, part_vec_s;
    logic [IDX_W-1:0]     full_idx_s, part_idx_s;
    logic [CODE_W-1:0]    code_bits_s;
    logic [LENGTH-1:0]    len_s;
    logic [ACC_W-1:0]     tmp_s;
    logic [FILL_W:0]      nf_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 clear_s;

    assign ready_s  = (state_q == S_RUN) && !bus.i_flush && (!o_valid_q || bus.i_ready);
    assign accept_s = bus.i_valid && ready_s;
    // Codes 01 and 11 both have bit 0 set and are exactly the ones that push.
    assign push_s   = accept_s && code_bits_s[0];

    assign tmp_s = acc_q | (ACC_W'(code_bits_s) << fill_q);
    assign nf_s  = {1'b0, fill_q} + {{(FILL_W+1-LENGTH){1'b0}}, len_s};

    assign bus.o_ready     = ready_s;
    assign bus.o_valid     = o_valid_q;
    assign bus.o_data      = o_data_q;
    assign bus.o_bits      = o_bits_q;
    assign bus.o_last      = o_last_q;
    assign bus.o_flush_ack = o_flush_ack_q;

    // Per-entry full and upper-half match flags against valid dictionary slots.
    always_comb begin
        full_vec_s = '0;
        part_vec_s = '0;
        for (int i = 0; i < WORD; i++) begin
            full_vec_s[i] = dict_vld_q[i] && (dict_q[i] == bus.i_data);
            part_vec_s[i] = dict_vld_q[i] && (dict_q[i][WIDTH-1:HALF] == bus.i_data[WIDTH-1:HALF]);
        end
    end

    // Lowest-index match wins: scan downward so the last hit kept is the lowest.
    always_comb begin
        full_idx_s = '0;
        part_idx_s = '0;
        for (int i = WORD - 1; i >= 0; i--) begin
            full_idx_s = full_vec_s[i] ? IDX_W'(i) : full_idx_s;
            part_idx_s = part_vec_s[i] ? IDX_W'(i) : part_idx_s;
        end
    end

    // Code selection with priority zero > full > partial > uncompressed.
    always_comb begin
        code_bits_s = {bus.i_data, 2'b01};
        len_s       = LENGTH'(CODE_W);
        if (bus.i_data == '0) begin
            code_bits_s = '0;
            len_s       = LENGTH'(LENGTH_CODE);
        end else if (|full_vec_s) begin
            code_bits_s = CODE_W'({full_idx_s, 2'b10});
            len_s       = LENGTH'(LENGTH_CODE + IDX_W);
        end else if (|part_vec_s) begin
            code_bits_s = CODE_W'({bus.i_data[HALF-1:0], part_idx_s, 2'b11});
            len_s       = LENGTH'(LENGTH_CODE + IDX_W + HALF);
        end else begin
            code_bits_s = {bus.i_data, 2'b01};
            len_s       = LENGTH'(CODE_W);
        end
    end

    // Next-state, packing and output-register logic.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        fill_d        = fill_q;
        o_data_d      = o_data_q;
        o_bits_d      = o_bits_q;
        o_last_d      = o_last_q;
        o_valid_d     = o_valid_q && !bus.i_ready;
        o_flush_ack_d = 1'b0;
        clear_s       = 1'b0;
        case (state_q)
            S_RUN: begin
                if (accept_s) begin
                    if (nf_s >= BEAT_BITS) begin
                        o_data_d  = tmp_s[O_WIDTH-1:0];
                        o_bits_d  = FULL_BITS;
                        o_last_d  = 1'b0;
                        o_valid_d = 1'b1;
                        acc_d     = tmp_s >> O_WIDTH;
                        fill_d    = FILL_W'(nf_s - BEAT_BITS);
                    end else begin
                        acc_d  = tmp_s;
                        fill_d = nf_s[FILL_W-1:0];
                    end
                    state_d = S_RUN;
                end else if (bus.i_flush) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (!o_valid_q || bus.i_ready) begin
                    if (fill_q != '0) begin
                        o_data_d  = acc_q[O_WIDTH-1:0];
                        o_bits_d  = fill_q;
                        o_last_d  = 1'b1;
                        o_valid_d = 1'b1;
                    end else begin
                        o_valid_d = 1'b0;
                    end
                    acc_d         = '0;
                    fill_d        = '0;
                    clear_s       = 1'b1;
                    o_flush_ack_d = 1'b1;
                    state_d       = S_ACK;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_ACK: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= S_RUN;
            acc_q         <= '0;
            fill_q        <= '0;
            o_data_q      <= '0;
            o_bits_q      <= '0;
            o_last_q      <= 1'b0;
            o_valid_q     <= 1'b0;
            o_flush_ack_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            fill_q        <= fill_d;
            o_data_q      <= o_data_d;
            o_bits_q      <= o_bits_d;
            o_last_q      <= o_last_d;
            o_valid_q     <= o_valid_d;
            o_flush_ack_q <= o_flush_ack_d;
        end
    end

    // FIFO dictionary: slot 0 newest, a push shifts everything up and evicts the top slot.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            dict_vld_q <= '0;
            for (int i = 0; i < WORD; i++) begin
                dict_q[i] <= '0;
            end
        end else if (clear_s) begin
            dict_vld_q <= '0;
        end else if (push_s) begin
            for (int i = WORD - 1; i > 0; i--) begin
                dict_q[i] <= dict_q[i-1];
            end
            dict_q[0]  <= bus.i_data;
            dict_vld_q <= {dict_vld_q[WORD-2:0], 1'b1};
        end
    end
endmodule

// File: tb/tb_word_compressor.sv
// Randomised scoreboard bench for word_compressor: a bit-queue reference model
// produces expected beats, a separate monitor compares them as the DUT emits them.
module tb_word_compressor;
    typedef struct {
        logic [127:0] d;
        logic [7:0]   b;
        logic         l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    word_compressor_if #(.WIDTH(32), .O_WIDTH(128), .FILL_W(8)) bus ();

    word_compressor dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad = 0;
    beat_t exp_q[$];
    bit    bq[$];
    logic [31:0] dict[$];
    logic [127:0] last_rx_d = '0;
    logic [7:0]   last_rx_b = '0;
    logic         last_rx_l = 1'b0;
    bit stall = 1'b0;
    bit rand_rdy = 1'b0;

    // Reference model: encode one accepted word into the bit stream.
    task automatic model_word(input logic [31:0] w);
        logic [33:0] c;
        int len;
        int idx;
        beat_t e;
        idx = -1;
        if (w == 32'd0) begin
            c = 34'd0; len = 2;
        end else begin
            for (int i = 0; i < dict.size(); i++) if (idx < 0 && dict[i] == w) idx = i;
            if (idx >= 0) begin
                c = {28'd0, idx[3:0], 2'b10}; len = 6;
            end else begin
                for (int i = 0; i < dict.size(); i++) if (idx < 0 && dict[i][31:16] == w[31:16]) idx = i;
                if (idx >= 0) begin
                    c = {12'd0, w[15:0], idx[3:0], 2'b11}; len = 22;
                end else begin
                    c = {w, 2'b01}; len = 34;
                end
                dict.push_front(w);
                if (dict.size() > 16) void'(dict.pop_back());
            end
        end
        for (int i = 0; i < len; i++) bq.push_back(c[i]);
        while (bq.size() >= 128) begin
            e.d = '0;
            for (int i = 0; i < 128; i++) e.d[i] = bq.pop_front();
            e.b = 8'd128; e.l = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic model_flush();
        beat_t e;
        int n;
        n = bq.size();
        if (n > 0) begin
            e.d = '0;
            for (int i = 0; i < n; i++) e.d[i] = bq.pop_front();
            e.b = 8'(n); e.l = 1'b1;
            exp_q.push_back(e);
        end
        dict.delete();
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Present one word until accepted (bounded), updating the model on the accept edge.
    task automatic send_word(input logic [31:0] w);
        bit done = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                model_word(w);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL accept_timeout: word %h never accepted", w);
        end
    endtask

    task automatic do_flush(input bit expect_beat);
        bit seen = 1'b0;
        int nexp;
        nexp = exp_q.size();
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b1;
        model_flush();
        total++;
        if ((exp_q.size() > nexp) != expect_beat) begin
            bad++;
            $display("FAIL flush_beat_expectation: model beat %0d want %0d", exp_q.size() > nexp, expect_beat);
        end
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (bus.o_flush_ack) seen = 1'b1;
        end
        bus.i_flush = 1'b0;
        check("flush_ack_seen", {127'd0, seen}, 128'd1);
        @(negedge clk);
        check("flush_ack_one_cycle", {127'd0, bus.o_flush_ack}, 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 128'(exp_q.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    // Downstream ready: random or forced, changed just after each rising edge.
    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.i_ready = stall ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: compare every transferred beat with the head of the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_valid && bus.i_ready) begin
                total++;
                last_rx_d = bus.o_data; last_rx_b = bus.o_bits; last_rx_l = bus.o_last;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got %h bits %0d last %0d", bus.o_data, bus.o_bits, bus.o_last);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.o_data !== e.d || bus.o_bits !== e.b || bus.o_last !== e.l) begin
                        bad++;
                        $display("FAIL beat: got %h/%0d/%0d want %h/%0d/%0d",
                                 bus.o_data, bus.o_bits, bus.o_last, e.d, e.b, e.l);
                    end
                end
            end
        end
    end

    initial begin
        logic [127:0] snap;
        logic [31:0] w;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_o_valid", {127'd0, bus.o_valid}, 128'd0);
        check("rst_o_last", {127'd0, bus.o_last}, 128'd0);
        check("rst_o_flush_ack", {127'd0, bus.o_flush_ack}, 128'd0);
        check("rst_o_data", bus.o_data, 128'd0);
        check("rst_o_bits", {120'd0, bus.o_bits}, 128'd0);
        check("rst_o_ready", {127'd0, bus.o_ready}, 128'd1);
        @(posedge clk); #1;

        // 64 zero words -> one all-zero full beat
        for (int i = 0; i < 64; i++) send_word(32'd0);
        drain();
        check("zero_beat_data", last_rx_d, 128'd0);
        check("zero_beat_bits", {120'd0, last_rx_b}, 128'd128);

        // Repeat word then flush with fill 40
        send_word(32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        do_flush(1'b1);
        drain();
        check("flush40_data", last_rx_d, {88'd0, 4'd0, 2'b10, 32'hDEADBEEF, 2'b01});
        check("flush40_bits", {120'd0, last_rx_b}, 128'd40);
        check("flush40_last", {127'd0, last_rx_l}, 128'd1);
        send_word(32'hDEADBEEF);
        do_flush(1'b1);
        do_flush(1'b0);

        // Partial match
        send_word(32'h12340000);
        send_word(32'h1234ABCD);
        do_flush(1'b1);

        // Eviction: repeat of the first word after 17 distinct words
        for (int i = 0; i < 17; i++) send_word({16'(i + 1), 16'hA5A5});
        send_word({16'd1, 16'hA5A5});
        do_flush(1'b1);
        for (int i = 0; i < 17; i++) send_word({16'(i + 1), 16'hA5A5});
        send_word({16'd17, 16'hA5A5});
        do_flush(1'b1);
        drain();

        // Backpressure with 34-bit codes
        stall = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8 && !bus.o_valid; i++) send_word({16'(16'h100 + i), 16'h5A5A});
        @(negedge clk);
        check("bp_valid", {127'd0, bus.o_valid}, 128'd1);
        snap = bus.o_data;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h77770001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready_low", {127'd0, bus.o_ready}, 128'd0);
            check("bp_data_stable", bus.o_data, snap);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        send_word(32'h77770001);
        do_flush(1'b1);
        drain();

        // Randomised traffic with random backpressure and flushes
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: w = 32'd0;
                1, 2, 3: w = (dict.size() > 0) ? dict[$urandom_range(0, dict.size() - 1)] : $urandom;
                4, 5: w = (dict.size() > 0) ? {dict[$urandom_range(0, dict.size() - 1)][31:16], 16'($urandom)} : $urandom;
                default: w = $urandom;
            endcase
            send_word(w);
            if ($urandom_range(0, 39) == 0) do_flush(bq.size() > 0);
        end
        do_flush(bq.size() > 0);
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
